// File: rtl/bcd_count_multi.sv
// ============================================================================
// bcd_count_multi
// ----------------------------------------------------------------------------
// Cascaded multi-digit BCD counter with synchronous parallel load, a
// terminal-count indicator and a sticky illegal-load flag.
//
// Parameters
//   DIGITS  number of cascaded BCD digits (1..8), default 4
//   WRAP    1 = roll over at the terminal value, 0 = saturate there
//
// Optional feature
//   BCD_COUNT_UPDOWN_EN  when defined, adds the up_down port and enables
//                        counting in both directions. When undefined the
//                        counter only counts up and all-9s is the only
//                        terminal value.
//
// Ports
//   clk       in   1          rising-edge clock, single clock domain
//   reset     in   1          asynchronous, active-high reset
//   enable    in   1          count enable
//   load      in   1          synchronous parallel load (priority over enable)
//   load_val  in   4*DIGITS   load value, digit i at bits [4i+3:4i]
//   up_down   in   1          1 = up, 0 = down (BCD_COUNT_UPDOWN_EN only)
//   Q         out  4*DIGITS   registered count, digit 0 least significant
//   tc        out  1          terminal count (combinational)
//   err       out  1          sticky illegal-load flag (registered)
//
// There is no handshake and no state machine: every input is sampled on
// each rising edge and the only state is the count register and err.
// ============================================================================
module bcd_count_multi #(
    parameter int DIGITS = 4,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
`ifdef BCD_COUNT_UPDOWN_EN
    input  logic                  up_down,
`endif
    output logic [4*DIGITS-1:0]   Q,
    output logic                  tc,
    output logic                  err
);

    localparam int W = 4 * DIGITS;

    // ------------------------------------------------------------------
    // Count direction
    // ------------------------------------------------------------------
    logic dir_up;

`ifdef BCD_COUNT_UPDOWN_EN
    assign dir_up = up_down;
`else
    assign dir_up = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Combinational next-state and status
    // ------------------------------------------------------------------
    logic [W-1:0] count_next;   // Q after one count step (always wraps)
    logic [W-1:0] load_clean;   // load_val with illegal digits forced to 0
    logic         load_bad;     // at least one load_val digit exceeds 9
    logic         all9;         // every digit of Q equals 9
    logic         all0;         // every digit of Q equals 0
    logic         at_term;      // Q sits at the terminal value for dir_up
    logic         carry;        // digit i steps when all lower digits ripple
    logic [3:0]   d;            // current digit of Q under inspection
    logic [3:0]   lv;           // current digit of load_val under inspection

    always_comb begin
        count_next = Q;
        load_clean = '0;
        load_bad   = 1'b0;
        all9       = 1'b1;
        all0       = 1'b1;
        carry      = 1'b1;      // digit 0 always steps
        d          = 4'd0;
        lv         = 4'd0;

        for (int i = 0; i < DIGITS; i++) begin
            d = Q[4*i +: 4];

            // A stepping digit moves one place; at its boundary it rolls
            // (9 -> 0 up, 0 -> 9 down) and lets the carry ripple upward.
            if (carry) begin
                if (dir_up) begin
                    count_next[4*i +: 4] = (d >= 4'd9) ? 4'd0 : d + 4'd1;
                end else begin
                    count_next[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
                end
            end
            carry = carry & (dir_up ? (d == 4'd9) : (d == 4'd0));

            all9 = all9 & (d == 4'd9);
            all0 = all0 & (d == 4'd0);

            // Load sanitising: any non-decimal nibble becomes 0 so Q can
            // never present a digit above 9.
            lv = load_val[4*i +: 4];
            if (lv > 4'd9) begin
                load_clean[4*i +: 4] = 4'd0;
                load_bad             = 1'b1;
            end else begin
                load_clean[4*i +: 4] = lv;
            end
        end
    end

    assign at_term = dir_up ? all9 : all0;

    // tc looks at the live inputs so it flags the cycle in which the next
    // enabled edge would wrap (or would be blocked by saturation).
    assign tc = enable & ~load & at_term;

    // Saturating build: an enabled step at the terminal value is ignored.
    logic hold_sat;
    assign hold_sat = (WRAP == 0) && at_term;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q   <= '0;
            err <= 1'b0;
        end else if (load) begin
            Q   <= load_clean;
            err <= err | load_bad;   // sticky until reset
        end else if (enable && !hold_sat) begin
            Q   <= count_next;
        end
    end

endmodule

// File: tb/tb_bcd_count_multi.sv
// ============================================================================
// tb_bcd_count_multi
// ----------------------------------------------------------------------------
// Drives two DIGITS=2 counters (one rolling over, one saturating) from the
// same inputs and compares both against a decimal-integer reference model.
// Directed steps cover reset, wrap, saturation, illegal load, hold and
// (with BCD_COUNT_UPDOWN_EN) down-counting, followed by random stimulus.
// ============================================================================
module tb_bcd_count_multi;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 100;          // 10**DIGITS

  // --------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         load;
  logic [W-1:0] load_val;
`ifdef BCD_COUNT_UPDOWN_EN
  logic         up_down;
`endif
  logic [W-1:0] q_w, q_s;
  logic         tc_w, tc_s, err_w, err_s;

  always #5 clk = ~clk;

  bcd_count_multi #(.DIGITS(DIGITS), .WRAP(1)) dut_wrap (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .load_val (load_val),
`ifdef BCD_COUNT_UPDOWN_EN
    .up_down  (up_down),
`endif
    .Q        (q_w),
    .tc       (tc_w),
    .err      (err_w)
  );

  bcd_count_multi #(.DIGITS(DIGITS), .WRAP(0)) dut_sat (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .load_val (load_val),
`ifdef BCD_COUNT_UPDOWN_EN
    .up_down  (up_down),
`endif
    .Q        (q_s),
    .tc       (tc_s),
    .err      (err_s)
  );

  // --------------------------------------------------------------------
  // Reference model: counts as plain decimal integers
  // --------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int mv_w     = 0;   // value of rolling counter
  int mv_s     = 0;   // value of saturating counter
  bit merr     = 1'b0;

  function automatic bit cur_up();
`ifdef BCD_COUNT_UPDOWN_EN
    return up_down;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [W-1:0] v);
    int acc;
    int dg;
    acc = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dg  = int'(v[4*i +: 4]);
      if (dg > 9) dg = 0;
      acc = acc * 10 + dg;
    end
    return acc;
  endfunction

  function automatic bit load_illegal(input logic [W-1:0] v);
    bit b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic bit model_tc(input int v);
    return enable && !load && (cur_up() ? (v == MAXV - 1) : (v == 0));
  endfunction

  task automatic model_step();
    if (reset) begin
      mv_w = 0; mv_s = 0; merr = 1'b0;
    end else if (load) begin
      mv_w = load_value(load_val);
      mv_s = mv_w;
      if (load_illegal(load_val)) merr = 1'b1;
    end else if (enable) begin
      if (cur_up()) begin
        mv_w = (mv_w + 1) % MAXV;
        mv_s = (mv_s < MAXV - 1) ? mv_s + 1 : MAXV - 1;
      end else begin
        mv_w = (mv_w + MAXV - 1) % MAXV;
        mv_s = (mv_s > 0) ? mv_s - 1 : 0;
      end
    end
  endtask

  // --------------------------------------------------------------------
  // Scoreboard check
  // --------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // --------------------------------------------------------------------
  // Driver tasks (called at the falling edge)
  // --------------------------------------------------------------------
  task automatic cycle();
    #1;
    check("tc_wrap", 32'(tc_w), 32'(model_tc(mv_w)));
    check("tc_sat",  32'(tc_s), 32'(model_tc(mv_s)));
    @(posedge clk);
    model_step();
    #1;
    check("q_wrap",   32'(q_w),   32'(to_bcd(mv_w)));
    check("q_sat",    32'(q_s),   32'(to_bcd(mv_s)));
    check("err_wrap", 32'(err_w), 32'(merr));
    check("err_sat",  32'(err_s), 32'(merr));
    @(negedge clk);
  endtask

  task automatic drive(input bit en, input bit ld, input logic [W-1:0] lv, input bit ud);
    enable   = en;
    load     = ld;
    load_val = lv;
`ifdef BCD_COUNT_UPDOWN_EN
    up_down  = ud;
`else
    if (ud) ;   // direction only exists in the up/down build
`endif
    cycle();
  endtask

  // Assert reset between edges and confirm it acts without a clock edge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    mv_w = 0; mv_s = 0; merr = 1'b0;
    #1;
    check("async_q_wrap", 32'(q_w),   32'h0);
    check("async_q_sat",  32'(q_s),   32'h0);
    check("async_err",    32'(err_w), 32'h0);
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------
  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    load     = 1'b0;
    load_val = '0;
`ifdef BCD_COUNT_UPDOWN_EN
    up_down  = 1'b1;
`endif
    @(negedge clk);
    check("reset_q",   32'(q_w),   32'h0);
    check("reset_err", 32'(err_w), 32'h0);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    reset = 1'b0;

    // Illegal load with enable high, then a legal load keeps err set.
    drive(1'b1, 1'b1, 8'hA5, 1'b1);
    check("illegal_load_q",   32'(q_w),   32'h05);
    check("illegal_load_err", 32'(err_w), 32'h1);
    drive(1'b0, 1'b1, 8'h42, 1'b1);
    check("legal_load_q",   32'(q_w),   32'h42);
    check("err_sticky",     32'(err_s), 32'h1);

    // Mid-cycle reset at 0x37, reset held two cycles with load pending.
    drive(1'b0, 1'b1, 8'h37, 1'b1);
    check("load_37", 32'(q_w), 32'h37);
    enable = 1'b1;
    async_reset();
    drive(1'b1, 1'b1, 8'h55, 1'b1);
    drive(1'b1, 1'b1, 8'h55, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 8'h00, 1'b1);
    check("after_reset_12", 32'(q_w), 32'h12);

    // Roll over from 0x98.
    drive(1'b0, 1'b1, 8'h98, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    check("wrap_99", 32'(q_w), 32'h99);
    #1;
    check("wrap_tc_at_99", 32'(tc_w), 32'h1);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    check("wrap_00", 32'(q_w), 32'h00);
    #1;
    check("wrap_tc_at_00", 32'(tc_w), 32'h0);

    // Saturation at 0x99 for three enabled cycles.
    drive(1'b0, 1'b1, 8'h99, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      check("sat_hold_99", 32'(q_s), 32'h99);
      #1;
      check("sat_tc", 32'(tc_s), 32'h1);
    end

`ifdef BCD_COUNT_UPDOWN_EN
    // Down-count across a digit boundary.
    drive(1'b0, 1'b1, 8'h10, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    check("down_09", 32'(q_w), 32'h09);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    check("down_08", 32'(q_w), 32'h08);
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    check("down_wrap_99", 32'(q_w), 32'h99);
    check("down_sat_00",  32'(q_s), 32'h00);
`endif

    // Hold with enable low.
    drive(1'b0, 1'b1, 8'h57, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("hold_57", 32'(q_w), 32'h57);
      #1;
      check("hold_tc", 32'(tc_w), 32'h0);
    end

    // Random stimulus against the model.
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] lv;
      int r;
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 5))
        0:       lv = 8'h99;
        1:       lv = 8'h00;
        2:       lv = ($urandom_range(0, 1) != 0) ? 8'h98 : 8'h01;
        default: begin
          lv[3:0] = 4'($urandom_range(0, 11));
          lv[7:4] = 4'($urandom_range(0, 11));
        end
      endcase
      if (r >= 98) begin
        async_reset();
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        reset = 1'b0;
      end else begin
        drive(($urandom_range(0, 3) != 0), (r < 10), lv, ($urandom_range(0, 2) != 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
